// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_det_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] PATTERN = 4'b1011;

  // Each state records how many leading bits of the pattern have been seen.
  typedef enum logic [STATE_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage

// File: rtl/seq_detector_1011_if.sv
// Bit-stream and result bundle between the bit source and the 1011 detector.
interface seq_detector_1011_if
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic               en;
  logic               din;
  logic               clr;
  logic               detect;
  logic               detect_b;
  logic [CNT_W-1:0]   match_cnt;
  logic [STATE_W-1:0] state_o;

  modport master (
    output en, din, clr,
    input  detect, detect_b, match_cnt, state_o
  );

  modport slave (
    input  en, din, clr,
    output detect, detect_b, match_cnt, state_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1011 (MSB first) with a saturating match counter.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_detector_1011_if.slave       bus
);

  state_t state;
  state_t state_nxt;
  logic   match_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S0:    if (bus.en) state_nxt = bus.din ? S1    : S0;
      S1:    if (bus.en) state_nxt = bus.din ? S1    : S10;
      S10:   if (bus.en) state_nxt = bus.din ? S101  : S0;
      S101:  if (bus.en) state_nxt = bus.din ? S1011 : S10;
      // Without overlap a trailing 0 cannot reuse the "10" tail of the match.
      S1011: if (bus.en) state_nxt = bus.din ? S1 : (OVERLAP ? S10 : S0);
      default: state_nxt = S0;
    endcase
  end

  assign match_inc = bus.en && (state_nxt == S1011);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .inc   (match_inc),
    .cnt   (bus.match_cnt)
  );

  assign bus.detect   = (state == S1011);
  assign bus.detect_b = ~bus.detect;
  assign bus.state_o  = state;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: three parameterisations driven in lockstep against a bit-history model.
module tb_seq_detector_1011;

  logic clk = 1'b0;
  logic rst_n;
  logic en, din, clr;

  always #5 clk = ~clk;

  seq_detector_1011_if #(.CNT_W(8)) if_a ();
  seq_detector_1011_if #(.CNT_W(8)) if_b ();
  seq_detector_1011_if #(.CNT_W(2)) if_c ();

  assign if_a.en = en;  assign if_a.din = din;  assign if_a.clr = clr;
  assign if_b.en = en;  assign if_b.din = din;  assign if_b.clr = clr;
  assign if_c.en = en;  assign if_c.din = din;  assign if_c.clr = clr;

  seq_detector_1011 #(.CNT_W(8), .OVERLAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  seq_detector_1011 #(.CNT_W(8), .OVERLAP(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  seq_detector_1011 #(.CNT_W(2), .OVERLAP(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_vec = 0;
  int n_err = 0;

  // Model: per instance, the accepted bits since the last restart point.
  bit hq[3][$];
  int ms[3];
  int mc[3];
  bit ov[3] = '{1'b1, 1'b0, 1'b0};
  int mx[3] = '{255, 255, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Longest suffix of the history that is a prefix of 1011.
  function automatic int pfx(input bit h[$]);
    logic [3:0] pat;
    bit ok;
    pat = 4'b1011;
    for (int k = 4; k >= 1; k--) begin
      if (h.size() >= k) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (h[h.size() - k + j] != pat[3 - j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic compare();
    check("a_detect",   32'(if_a.detect),    32'(ms[0] == 4));
    check("a_detect_b", 32'(if_a.detect_b),  32'(ms[0] != 4));
    check("a_cnt",      32'(if_a.match_cnt), 32'(mc[0]));
    check("a_state",    32'(if_a.state_o),   32'(ms[0]));
    check("b_detect",   32'(if_b.detect),    32'(ms[1] == 4));
    check("b_detect_b", 32'(if_b.detect_b),  32'(ms[1] != 4));
    check("b_cnt",      32'(if_b.match_cnt), 32'(mc[1]));
    check("b_state",    32'(if_b.state_o),   32'(ms[1]));
    check("c_detect",   32'(if_c.detect),    32'(ms[2] == 4));
    check("c_cnt",      32'(if_c.match_cnt), 32'(mc[2]));
    check("c_state",    32'(if_c.state_o),   32'(ms[2]));
  endtask

  task automatic step(input bit d, input bit e, input bit c, input bit r);
    din = d; en = e; clr = c; rst_n = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        hq[i].delete();
        ms[i] = 0;
        mc[i] = 0;
      end else begin
        if (e) begin
          if (!ov[i] && ms[i] == 4) hq[i].delete();
          hq[i].push_back(d);
          if (hq[i].size() > 4) void'(hq[i].pop_front());
          ms[i] = pfx(hq[i]);
        end
        if (c) mc[i] = 0;
        else if (e && ms[i] == 4 && mc[i] < mx[i]) mc[i]++;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    din = 1'b0; en = 1'b0; clr = 1'b0; rst_n = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    check("rst_state",    32'(if_a.state_o),   32'd0);
    check("rst_detect_b", 32'(if_a.detect_b),  32'd1);
    check("rst_cnt",      32'(if_a.match_cnt), 32'd0);

    // Single 1011 then a trailing 0
    feed(16'b1011, 4);
    check("t1_detect",   32'(if_a.detect),    32'd1);
    check("t1_detect_b", 32'(if_a.detect_b),  32'd0);
    check("t1_cnt",      32'(if_a.match_cnt), 32'd1);
    check("t1_state",    32'(if_a.state_o),   32'd4);
    feed(16'b0, 1);
    check("t1_next_detect", 32'(if_a.detect),  32'd0);
    check("t1_next_state",  32'(if_a.state_o), 32'd2);

    // Overlapping vs non-overlapping on 1011011
    do_reset();
    feed(16'b1011011, 7);
    check("ov_detect_a", 32'(if_a.detect),    32'd1);
    check("ov_detect_b", 32'(if_b.detect),    32'd0);
    check("ov_cnt_a",    32'(if_a.match_cnt), 32'd2);
    check("ov_cnt_b",    32'(if_b.match_cnt), 32'd1);

    // Enable gap holds the partial match
    do_reset();
    feed(16'b101, 3);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b0, 1'b0, 1'b1);
      check("gap_state", 32'(if_a.state_o), 32'd3);
    end
    feed(16'b1, 1);
    check("gap_detect", 32'(if_a.detect),    32'd1);
    check("gap_cnt",    32'(if_a.match_cnt), 32'd1);

    // Five back-to-back matches: 2-bit counter saturates
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed(16'b1011, 4);
      check("sat_cnt_c", 32'(if_c.match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat_cnt_a", 32'(if_a.match_cnt), 32'd5);
    check("sat_cnt_b", 32'(if_b.match_cnt), 32'd5);

    // Clear coinciding with a completing match
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_cnt",    32'(if_a.match_cnt), 32'd0);
    check("clr_detect", 32'(if_a.detect),    32'd1);
    check("clr_state",  32'(if_a.state_o),   32'd4);

    // Reset mid-sequence discards the partial match
    feed(16'b101, 3);
    do_reset();
    check("mid_state",    32'(if_a.state_o),   32'd0);
    check("mid_detect",   32'(if_a.detect),    32'd0);
    check("mid_detect_b", 32'(if_a.detect_b),  32'd1);
    check("mid_cnt",      32'(if_a.match_cnt), 32'd0);
    feed(16'b1, 1);
    check("mid_next_state", 32'(if_a.state_o),   32'd1);
    check("mid_next_cnt",   32'(if_a.match_cnt), 32'd0);

    // Assorted stream with clr and en gaps, model-checked only
    feed(16'b1101_1011_0110_1101, 16);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    feed(16'b0110_1110_1011, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
